// File: rtl/spi_apb_master_bridge.sv
// APB3 completer around an 8-bit SPI mode-0 master (MSB first, one frame per START).
// Optional: define SPI_APB_IRQ_EN to add the registered irq_o = DONE & IE output.
module spi_apb_master_bridge #(
   parameter logic [7:0] CLKDIV_RST = 8'd1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [4:0]  paddr_bi,
   input  logic [31:0] pwdata_bi,
   output logic [31:0] prdata_bo,
   output logic        pready_o,
   output logic        pslverr_o,
`ifdef SPI_APB_IRQ_EN
   output logic        irq_o,
`endif
   input  logic        spi_miso_i,
   output logic        spi_mosi_o,
   output logic        spi_sclk_o,
   output logic        spi_cs_o
);

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL} state_t;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_TX     = 3'd2;
   localparam logic [2:0] A_RX     = 3'd3;
   localparam logic [2:0] A_DIV    = 3'd4;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] div_q, div_d;
   logic [3:0] bit_q, bit_d;
   logic [7:0] txsh_q, txsh_d;
   logic [7:0] rxsh_q, rxsh_d;
   logic [7:0] txdata_q, txdata_d;
   logic [7:0] rxdata_q, rxdata_d;
   logic [7:0] clkdiv_q, clkdiv_d;
   logic       ie_q, ie_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       cs_q, cs_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;

   logic       acc, wr, busy, phase_end, err_set;
   logic       wr_ctrl, wr_status, wr_tx, wr_div, start_req;
   logic [2:0] sel;
   logic       unused_bits;

   assign unused_bits = &{1'b0, paddr_bi[1:0], pwdata_bi[31:8]};

   assign acc       = psel_i & penable_i;
   assign wr        = acc & pwrite_i;
   assign sel       = paddr_bi[4:2];
   assign busy      = (state_q != S_IDLE);
   assign phase_end = (cnt_q == 8'd0);
   assign wr_ctrl   = wr && (sel == A_CTRL);
   assign wr_status = wr && (sel == A_STATUS);
   assign wr_tx     = wr && (sel == A_TX);
   assign wr_div    = wr && (sel == A_DIV);
   assign start_req = wr_ctrl & pwdata_bi[0];

   assign pready_o   = 1'b1;
   assign pslverr_o  = acc && (sel > A_DIV);
   assign spi_cs_o   = cs_q;
   assign spi_sclk_o = sclk_q;
   assign spi_mosi_o = mosi_q;

   always_comb begin
      prdata_bo = 32'd0;
      if (acc) begin
         case (sel)
            A_CTRL:   prdata_bo = {30'd0, ie_q, 1'b0};
            A_STATUS: prdata_bo = {29'd0, err_q, done_q, busy};
            A_TX:     prdata_bo = {24'd0, txdata_q};
            A_RX:     prdata_bo = {24'd0, rxdata_q};
            A_DIV:    prdata_bo = {24'd0, clkdiv_q};
            default:  prdata_bo = 32'd0;
         endcase
      end
   end

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      bit_d    = bit_q;
      txsh_d   = txsh_q;
      rxsh_d   = rxsh_q;
      txdata_d = txdata_q;
      rxdata_d = rxdata_q;
      clkdiv_d = clkdiv_q;
      ie_d     = ie_q;
      done_d   = done_q;
      err_d    = err_q;
      cs_d     = cs_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      err_set  = 1'b0;

      if (wr_ctrl) begin
         ie_d = pwdata_bi[1];
         if (pwdata_bi[0] && busy) err_set = 1'b1;
      end
      if (wr_tx) begin
         if (busy) err_set = 1'b1;
         else      txdata_d = pwdata_bi[7:0];
      end
      if (wr_div) begin
         if (busy) err_set = 1'b1;
         else      clkdiv_d = pwdata_bi[7:0];
      end
      if (wr_status) begin
         if (pwdata_bi[1]) done_d = 1'b0;
         if (pwdata_bi[2]) err_d  = 1'b0;
      end
      // Sets are applied after the W1C clears so a same-cycle set wins.
      if (err_set) err_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d = S_LEAD;
               cs_d    = 1'b0;
               txsh_d  = txdata_q;
               mosi_d  = txdata_q[7];
               cnt_d   = clkdiv_q;
               div_d   = clkdiv_q;
               bit_d   = 4'd0;
            end
         end
         S_LEAD, S_LOW: begin
            if (phase_end) begin
               sclk_d  = 1'b1;
               rxsh_d  = {rxsh_q[6:0], spi_miso_i};
               cnt_d   = div_q;
               state_d = S_HIGH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HIGH: begin
            if (phase_end) begin
               sclk_d = 1'b0;
               bit_d  = bit_q + 4'd1;
               cnt_d  = div_q;
               if (bit_q == 4'd7) begin
                  state_d = S_TRAIL;
               end else begin
                  txsh_d  = {txsh_q[6:0], 1'b0};
                  mosi_d  = txsh_q[6];
                  state_d = S_LOW;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_TRAIL: begin
            if (phase_end) begin
               cs_d     = 1'b1;
               rxdata_d = rxsh_q;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         div_q    <= 8'd0;
         bit_q    <= 4'd0;
         txsh_q   <= 8'd0;
         rxsh_q   <= 8'd0;
         txdata_q <= 8'd0;
         rxdata_q <= 8'd0;
         clkdiv_q <= CLKDIV_RST;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         txsh_q   <= txsh_d;
         rxsh_q   <= rxsh_d;
         txdata_q <= txdata_d;
         rxdata_q <= rxdata_d;
         clkdiv_q <= clkdiv_d;
         ie_q     <= ie_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cs_q     <= cs_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

`ifdef SPI_APB_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) irq_q <= 1'b0;
      else       irq_q <= done_q & ie_q;
   end

   assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_spi_apb_master_bridge.sv
// Self-checking bench for spi_apb_master_bridge: APB host tasks, an SPI slave model and
// frame-level expectations (17*H CS-low cycles, 8 SCLK rises, byte exchange). Honors SPI_APB_IRQ_EN.
module tb_spi_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [4:0]  paddr = 5'd0;
   logic [31:0] pwdata = 32'd0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        spi_miso, spi_mosi, spi_sclk, spi_cs;
`ifdef SPI_APB_IRQ_EN
   logic        irq;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   spi_apb_master_bridge #(.CLKDIV_RST(8'd1)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .psel_i     (psel),
      .penable_i  (penable),
      .pwrite_i   (pwrite),
      .paddr_bi   (paddr),
      .pwdata_bi  (pwdata),
      .prdata_bo  (prdata),
      .pready_o   (pready),
      .pslverr_o  (pslverr),
`ifdef SPI_APB_IRQ_EN
      .irq_o      (irq),
`endif
      .spi_miso_i (spi_miso),
      .spi_mosi_o (spi_mosi),
      .spi_sclk_o (spi_sclk),
      .spi_cs_o   (spi_cs)
   );

   always #5 clk = ~clk;

   // SPI slave model: presents slave_tx MSB first, shifts on SCLK fall, captures MOSI on SCLK rise.
   logic       cs_prev = 1'b1, sclk_prev = 1'b0;
   logic       miso_r = 1'b0, loopback = 1'b0;
   logic [7:0] slave_tx = 8'd0, slave_sh = 8'd0, slave_rx = 8'd0, last_rx = 8'd0;
   int         frames = 0, low_cnt = 0, rise_cnt = 0, last_low = 0, last_rise = 0;

   assign spi_miso = loopback ? spi_mosi : miso_r;

   always @(negedge clk) begin
      if (cs_prev && !spi_cs) begin
         low_cnt  = 0;
         rise_cnt = 0;
         slave_rx = 8'd0;
         slave_sh = slave_tx;
         miso_r   = slave_tx[7];
      end
      if (!spi_cs) begin
         low_cnt++;
         if (spi_sclk && !sclk_prev) begin
            rise_cnt++;
            slave_rx = {slave_rx[6:0], spi_mosi};
         end
         if (!spi_sclk && sclk_prev) begin
            slave_sh = slave_sh << 1;
            miso_r   = slave_sh[7];
         end
      end
      if (!cs_prev && spi_cs) begin
         frames++;
         last_low  = low_cnt;
         last_rise = rise_cnt;
         last_rx   = slave_rx;
      end
      cs_prev   = spi_cs;
      sclk_prev = spi_sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [4:0] addr, output logic [31:0] data, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(negedge clk);
      penable = 1'b1;
      #1;
      data = prdata;
      err  = pslverr;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(addr, d, e);
      check(tag, d, exp);
   endtask

   task automatic start_xfer(input logic [7:0] tx, input logic ie);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = {30'd0, ie, 1'b1};
      @(negedge clk);
      penable = 1'b1;
      #1;
      check("cs_before_start", spi_cs, 1'b1);
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      check("cs_after_start", spi_cs, 1'b0);
      check("mosi_lead", spi_mosi, tx[7]);
   endtask

   task automatic wait_frame(input int f0, input int budget);
      int n = 0;
      while (frames == f0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("frame_timeout", (frames == f0), 1'b0);
   endtask

   // Full transfer against the reference expectations derived from TX byte, slave byte and CLKDIV.
   task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] sb,
                           input logic [7:0] dv, input logic lb);
      int f0;
      int h;
      h = int'(dv) + 1;
      apb_write(5'h04, 32'h6);
      apb_write(5'h08, {24'd0, tx});
      apb_write(5'h10, {24'd0, dv});
      slave_tx = sb;
      loopback = lb;
      f0 = frames;
      start_xfer(tx, 1'b0);
      read_check({tag, "_busy"}, 5'h04, 32'h1);
      wait_frame(f0, 17 * h + 50);
      check({tag, "_cs_low"}, last_low, 17 * h);
      check({tag, "_sclk_rises"}, last_rise, 8);
      if (!lb) check({tag, "_slave_rx"}, {24'd0, last_rx}, {24'd0, tx});
      read_check({tag, "_rxdata"}, 5'h0C, lb ? {24'd0, tx} : {24'd0, sb});
      read_check({tag, "_status"}, 5'h04, 32'h2);
      loopback = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [7:0]  tx, sb, dv;
      int          f0, n;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_cs", spi_cs, 1'b1);
      check("rst_sclk", spi_sclk, 1'b0);
      check("rst_mosi", spi_mosi, 1'b0);
      check("rst_prdata_idle", prdata, 32'd0);
      check("rst_pready", pready, 1'b1);
      check("rst_pslverr", pslverr, 1'b0);
`ifdef SPI_APB_IRQ_EN
      check("rst_irq", irq, 1'b0);
`endif
      read_check("rst_ctrl", 5'h00, 32'h0);
      read_check("rst_status", 5'h04, 32'h0);
      read_check("rst_txdata", 5'h08, 32'h0);
      read_check("rst_rxdata", 5'h0C, 32'h0);
      read_check("rst_clkdiv", 5'h10, 32'h1);

      // Directed transfers
      run_xfer("t35", 8'h35, 8'hA3, 8'd1, 1'b0);
      run_xfer("loop_c6", 8'hC6, 8'h00, 8'd0, 1'b1);
      run_xfer("div255", 8'h81, 8'h7E, 8'd255, 1'b0);

      // Randomized transfers
      for (int i = 0; i < 6; i++) begin
         tx = 8'($urandom);
         sb = 8'($urandom);
         dv = 8'($urandom_range(0, 5));
         run_xfer("rand", tx, sb, dv, 1'b0);
      end

      // Writes while busy are rejected and flag ERR
      apb_write(5'h04, 32'h6);
      apb_write(5'h08, 32'h5A);
      apb_write(5'h10, 32'h3);
      slave_tx = 8'h3C;
      f0 = frames;
      start_xfer(8'h5A, 1'b0);
      apb_write(5'h00, 32'h1);
      apb_write(5'h08, 32'hFF);
      apb_write(5'h10, 32'h0);
      wait_frame(f0, 17 * 4 + 50);
      check("busy_wr_cs_low", last_low, 68);
      check("busy_wr_slave_rx", {24'd0, last_rx}, 32'h5A);
      read_check("busy_wr_txdata", 5'h08, 32'h5A);
      read_check("busy_wr_clkdiv", 5'h10, 32'h3);
      read_check("busy_wr_rxdata", 5'h0C, 32'h3C);
      read_check("busy_wr_status", 5'h04, 32'h6);
      apb_write(5'h04, 32'h6);
      read_check("w1c_status", 5'h04, 32'h0);

      // DONE set and W1C clear on the same edge: set wins
      apb_write(5'h10, 32'h0);
      f0 = frames;
      start_xfer(8'h11, 1'b0);
      repeat (15) @(posedge clk);
      apb_write(5'h04, 32'h2);
      wait_frame(f0, 50);
      check("collide_cs_low", last_low, 17);
      read_check("collide_done_kept", 5'h04, 32'h2);
      apb_write(5'h04, 32'h2);
      read_check("done_cleared", 5'h04, 32'h0);

      // Unmapped addresses
      apb_write(5'h14, 32'hFFFF_FFFF);
      for (int a = 5; a < 8; a++) begin
         apb_read(5'(a * 4), rd, er);
         check("unmapped_rdata", rd, 32'h0);
         check("unmapped_slverr", er, 1'b1);
      end
      apb_read(5'h08, rd, er);
      check("mapped_slverr", er, 1'b0);
      read_check("unmapped_wr_ignored", 5'h00, 32'h0);

`ifdef SPI_APB_IRQ_EN
      // Interrupt follows DONE & IE one cycle later
      f0 = frames;
      start_xfer(8'h99, 1'b1);
      wait_frame(f0, 50);
      check("irq_same_cycle", irq, 1'b0);
      @(negedge clk);
      #1;
      check("irq_rise", irq, 1'b1);
      apb_write(5'h04, 32'h2);
      check("irq_hold", irq, 1'b1);
      @(posedge clk);
      #1;
      check("irq_fall", irq, 1'b0);
      apb_write(5'h00, 32'h0);
`endif

      // Reset in the middle of a frame
      apb_write(5'h10, 32'h1);
      apb_write(5'h08, 32'hE7);
      slave_tx = 8'h55;
      start_xfer(8'hE7, 1'b0);
      n = 0;
      while (rise_cnt < 4 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_mid_reach", (rise_cnt >= 4), 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_cs", spi_cs, 1'b1);
      check("rst_mid_sclk", spi_sclk, 1'b0);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      read_check("rst_mid_status", 5'h04, 32'h0);
      read_check("rst_mid_clkdiv", 5'h10, 32'h1);
      read_check("rst_mid_txdata", 5'h08, 32'h0);
      read_check("rst_mid_rxdata", 5'h0C, 32'h0);
      check("rst_mid_cs_idle", spi_cs, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
